// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // The PISO shifts MSB first while the line wants LSB first, so the byte
  // handed to the PISO is mirrored.
  function automatic logic [UART_DATA_BITS-1:0] bit_reverse8(input logic [UART_DATA_BITS-1:0] value);
    logic [UART_DATA_BITS-1:0] result;
    result = '0;
    for (int i = 0; i < UART_DATA_BITS; i++) begin
      result[i] = value[UART_DATA_BITS-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
`timescale 1ns/1ps
// Bit-period timer: counts clock cycles within one serial bit and flags the
// final cycle so the controller can advance to the next bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done = ~clr & (cnt_q == LAST_CNT);

  // Hold at zero while cleared, otherwise count up and wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_done) begin
      cnt_d = '0;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// UART 8N1 transmit controller that drives an external MSB-first PISO and
// frames its serial output with start and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] piso_data,
  output logic       piso_load,
  output logic       piso_shift,
  input  logic       piso_out,
  output logic       tx_serial,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] piso_data_q;
  logic       piso_load_q;
  logic       baud_clr;
  logic       bit_done;

  // The bit timer idles at zero so a new frame always starts on a full bit.
  assign baud_clr = (state_q == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (baud_clr),
    .bit_done(bit_done)
  );

  // Frame sequencer: accepts a byte in IDLE, then walks START, eight DATA bits and STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      piso_data_q <= '0;
      piso_load_q <= 1'b0;
    end else begin
      piso_load_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_valid) begin
            piso_data_q <= bit_reverse8(tx_data);
            piso_load_q <= 1'b1;
            bit_cnt_q   <= '0;
            state_q     <= START;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Line mux: low for the start bit, PISO output for data, high otherwise.
  always_comb begin
    tx_serial = 1'b1;
    unique case (state_q)
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = piso_out;
      default: tx_serial = 1'b1;
    endcase
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign piso_data  = piso_data_q;
  assign piso_load  = piso_load_q;
  assign piso_shift = (state_q == DATA) && bit_done && (bit_cnt_q != LAST_BIT);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_tx_ctrl with a behavioural PISO alongside.
module tb_uart_tx_ctrl;

  localparam int CLKS         = 4;
  localparam int FRAME_CYCLES = 10 * CLKS;

  typedef struct {
    logic [7:0] expPiso;
    logic [9:0] expFrame;
    bit         checkPeriod;
    bit         expectAbort;
    string      name;
  } frameExp_t;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] piso_data;
  logic       piso_load;
  logic       piso_shift;
  logic       piso_out;
  logic       tx_serial;
  logic       busy;

  logic [7:0] pisoReg;
  frameExp_t  expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cycleCount = 0;
  int         lastLoadCycle = -1000;
  bit         monitorBusy = 0;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .piso_data (piso_data),
    .piso_load (piso_load),
    .piso_shift(piso_shift),
    .piso_out  (piso_out),
    .tx_serial (tx_serial),
    .busy      (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time load-to-load spacing.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural MSB-first PISO.
  always @(posedge clk) begin
    if (piso_load) pisoReg <= piso_data;
    else if (piso_shift) pisoReg <= {pisoReg[6:0], 1'b0};
  end
  assign piso_out = pisoReg[7];

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " tx_serial"}, 32'(tx_serial), 32'd1);
    checkOutput({name, " tx_ready"}, 32'(tx_ready), 32'd1);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " load/shift"}, 32'({piso_load, piso_shift}), 32'd0);
    checkOutput({name, " piso_data"}, 32'(piso_data), 32'd0);
  endtask

  // Follows one frame from its load pulse, comparing every cycle against the queued expectation.
  task automatic checkFrame(input frameExp_t item);
    int   shiftCount = 0;
    int   badShift = 0;
    int   badLoad = 0;
    int   badStatus = 0;
    bit   aborted = 0;
    bit   expShift;
    logic bitSeen = 1'b0;
    checkOutput({item.name, " piso_data"}, 32'(piso_data), 32'(item.expPiso));
    if (item.checkPeriod)
      checkOutput({item.name, " load period"}, 32'(cycleCount - lastLoadCycle), 32'(FRAME_CYCLES + 1));
    lastLoadCycle = cycleCount;
    for (int cyc = 0; cyc < FRAME_CYCLES; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (reset) begin
        aborted = 1;
        checkOutput({item.name, " abort tx_serial"}, 32'(tx_serial), 32'd1);
        checkOutput({item.name, " abort tx_ready"}, 32'(tx_ready), 32'd1);
        checkOutput({item.name, " abort strobes"}, 32'({piso_load, piso_shift}), 32'd0);
        checkOutput({item.name, " abort piso_data"}, 32'(piso_data), 32'd0);
        break;
      end
      if (cyc % CLKS == 0) bitSeen = item.expFrame[cyc / CLKS];
      if (tx_serial !== item.expFrame[cyc / CLKS]) bitSeen = tx_serial;
      expShift = (cyc >= CLKS) && (cyc < 8 * CLKS) && (cyc % CLKS == CLKS - 1);
      if (piso_shift === 1'b1) shiftCount++;
      if (piso_shift !== expShift) badShift++;
      if (cyc > 0 && piso_load !== 1'b0) badLoad++;
      if (tx_ready !== 1'b0 || busy !== 1'b1) badStatus++;
      if (cyc % CLKS == CLKS - 1)
        checkOutput($sformatf("%s frame bit %0d", item.name, cyc / CLKS),
                    32'(bitSeen), 32'(item.expFrame[cyc / CLKS]));
    end
    checkOutput({item.name, " aborted"}, 32'(aborted), 32'(item.expectAbort));
    checkOutput({item.name, " extra loads"}, 32'(badLoad), 32'd0);
    checkOutput({item.name, " ready/busy cycles wrong"}, 32'(badStatus), 32'd0);
    if (!aborted) begin
      checkOutput({item.name, " shift count"}, 32'(shiftCount), 32'd7);
      checkOutput({item.name, " misplaced shifts"}, 32'(badShift), 32'd0);
      @(negedge clk);
      checkOutput({item.name, " end tx_ready"}, 32'(tx_ready), 32'd1);
      checkOutput({item.name, " end tx_serial"}, 32'(tx_serial), 32'd1);
      checkOutput({item.name, " end busy"}, 32'(busy), 32'd0);
    end
  endtask

  // Monitor: every load pulse pops the next expected frame.
  initial begin
    frameExp_t item;
    forever begin
      @(negedge clk);
      if (!reset && piso_load === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected load: got load of 0x%0h, expected none", piso_data);
        end else begin
          monitorBusy = 1;
          item = expQ.pop_front();
          checkFrame(item);
          monitorBusy = 0;
        end
      end
    end
  end

  task automatic waitReady(output bit ok);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait tx_ready: got no ready in 200 cycles, expected ready");
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] expPiso,
                               input logic [9:0] expFrame, input string name,
                               input bit expectAbort);
    bit        ok;
    frameExp_t item;
    waitReady(ok);
    if (!ok) return;
    item.expPiso     = expPiso;
    item.expFrame    = expFrame;
    item.checkPeriod = 0;
    item.expectAbort = expectAbort;
    item.name        = name;
    expQ.push_back(item);
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hA5;
  endtask

  // Directed stimulus; expected frames are written LSB-first: bit 0 = start, bit 9 = stop.
  initial begin
    bit        ok;
    frameExp_t item;
    int        waited;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    @(negedge clk);
    checkIdle("power-on reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("after power-on reset");

    applyStimulus(8'h2C, 8'h34, 10'b1001011000, "byte 0x2C", 0);

    waitReady(ok);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkIdle("idle reset asserted");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("idle reset released");

    applyStimulus(8'hFF, 8'hFF, 10'b1111111110, "byte 0xFF", 0);

    waitReady(ok);
    item.expPiso     = 8'hAA;
    item.expFrame    = 10'b1010101010;
    item.checkPeriod = 0;
    item.expectAbort = 0;
    item.name        = "b2b 0x55";
    expQ.push_back(item);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data          = 8'hAA;
    item.expPiso     = 8'h55;
    item.expFrame    = 10'b1101010100;
    item.checkPeriod = 1;
    item.name        = "b2b 0xAA";
    expQ.push_back(item);
    waitReady(ok);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;

    applyStimulus(8'hF0, 8'h0F, 10'b1111100000, "busy 0xF0", 0);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = i[0];
    end
    @(negedge clk);
    tx_valid = 1'b0;

    applyStimulus(8'h81, 8'h81, 10'b1100000010, "abort 0x81", 1);
    repeat (16) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    applyStimulus(8'h81, 8'h81, 10'b1100000010, "retry 0x81", 0);

    waited = 0;
    while ((expQ.size() != 0 || monitorBusy) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d frames outstanding, expected 0", expQ.size());
    end
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
